// File: rtl/access_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-user access controller.
package access_ctrl_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        COMPARE,
        GRANT,
        WRITE,
        DENY,
        LOCKOUT
    } state_e;

    // Data_In carries the change flag directly above the password bits
    function automatic int unsigned chg_flag_idx(input int unsigned pw_w);
        return pw_w;
    endfunction

    // Width of a per-user fail counter that must be able to hold max_fail
    function automatic int unsigned fail_cnt_w(input int unsigned max_fail);
        return (max_fail < 1) ? 1 : $clog2(max_fail + 1);
    endfunction

    // Width of a down-counter that is loaded with n-1
    function automatic int unsigned down_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/access_lockout_timer.sv
// Loadable down-counter; done_c is high while the count sits at zero.
module access_lockout_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done_c
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down while enabled, holding at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/multi_user_access_ctrl.sv
// Multi-user password checker: fetch stored password, compare, grant/deny,
// per-user fail counting with global lockout, and password change write-back.
module multi_user_access_ctrl
    import access_ctrl_pkg::*;
#(
    parameter int unsigned PW_W        = 16,
    parameter int unsigned USER_W      = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 1000,
    parameter int unsigned GRANT_CYC   = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PW_W:0]     Data_In,
    input  logic              Data_In_Load,
    input  logic [USER_W-1:0] User_Sel,
    input  logic [PW_W-1:0]   Memory_Data_In,
    output logic              Access_Grant,
    output logic [ADDR_W-1:0] Address,
    output logic              wren,
    output logic [PW_W-1:0]   Data_Out,
    output logic              Locked,
    output logic              Deny
);

    localparam int unsigned N_USERS = 2 ** USER_W;
    localparam int unsigned CHG_IDX = chg_flag_idx(PW_W);
    localparam int unsigned FC_W    = fail_cnt_w(MAX_FAIL);
    localparam int unsigned LAT_W   = down_cnt_w(MEM_LAT);
    localparam int unsigned LOCK_W  = down_cnt_w(LOCKOUT_CYC);
    localparam int unsigned GNT_W   = down_cnt_w(GRANT_CYC);

    state_e              state;
    state_e              state_nxt;
    logic [PW_W-1:0]     pw_reg;
    logic [PW_W-1:0]     mem_reg;
    logic [USER_W-1:0]   user_id;
    logic [LAT_W-1:0]    lat_cnt;
    logic [FC_W-1:0]     fail_cnt [N_USERS];

    logic                chg_flag_c;
    logic [PW_W-1:0]     din_pw_c;
    logic [FC_W-1:0]     fail_inc_c;
    logic                take_entry_c;
    logic                take_change_c;
    logic                capture_c;
    logic                fail_clr_c;
    logic                fail_bump_c;
    logic                lock_load_c;
    logic                lock_done_c;
    logic                gnt_load_c;
    logic                gnt_done_c;
    logic [ADDR_W-1:0]   user_addr_c;
    logic [ADDR_W-1:0]   addr_nxt_c;
    logic [PW_W-1:0]     dout_nxt_c;

    assign chg_flag_c = Data_In[CHG_IDX];
    assign din_pw_c   = Data_In[PW_W-1:0];

    // Saturating increment of the current user's fail count
    assign fail_inc_c = (fail_cnt[user_id] == FC_W'(MAX_FAIL)) ? fail_cnt[user_id]
                                                                : fail_cnt[user_id] + FC_W'(1);

    // New entries address the selected user; later phases reuse the latched ID
    assign user_addr_c = ADDR_W'(BASE_ADDR) + ADDR_W'(take_entry_c ? User_Sel : user_id);

    access_lockout_timer #(.W(LOCK_W)) u_lock_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (lock_load_c),
        .load_val (LOCK_W'(LOCKOUT_CYC - 1)),
        .en       (state == LOCKOUT),
        .done_c   (lock_done_c)
    );

    access_lockout_timer #(.W(GNT_W)) u_grant_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (gnt_load_c),
        .load_val (GNT_W'(GRANT_CYC - 1)),
        .en       (state == GRANT),
        .done_c   (gnt_done_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath strobes and next output values
    always_comb begin
        state_nxt     = state;
        take_entry_c  = 1'b0;
        take_change_c = 1'b0;
        capture_c     = 1'b0;
        fail_clr_c    = 1'b0;
        fail_bump_c   = 1'b0;
        lock_load_c   = 1'b0;
        gnt_load_c    = 1'b0;
        addr_nxt_c    = '0;
        dout_nxt_c    = '0;

        case (state)
            IDLE: begin
                if (Data_In_Load && !chg_flag_c) begin
                    take_entry_c = 1'b1;
                    state_nxt    = FETCH;
                end
            end
            FETCH: begin
                if (lat_cnt == '0) begin
                    capture_c = 1'b1;
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                if (pw_reg == mem_reg) begin
                    fail_clr_c = 1'b1;
                    gnt_load_c = 1'b1;
                    state_nxt  = GRANT;
                end else begin
                    state_nxt  = DENY;
                end
            end
            DENY: begin
                fail_bump_c = 1'b1;
                if (fail_inc_c == FC_W'(MAX_FAIL)) begin
                    lock_load_c = 1'b1;
                    state_nxt   = LOCKOUT;
                end else begin
                    state_nxt   = IDLE;
                end
            end
            LOCKOUT: begin
                if (lock_done_c) begin
                    fail_clr_c = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            GRANT: begin
                // A load on the expiry cycle takes priority over the timeout
                if (Data_In_Load) begin
                    if (chg_flag_c) begin
                        take_change_c = 1'b1;
                        state_nxt     = WRITE;
                    end else begin
                        state_nxt     = IDLE;
                    end
                end else if (gnt_done_c) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if ((state_nxt == FETCH) || (state_nxt == WRITE)) begin
            addr_nxt_c = user_addr_c;
        end
        if (take_change_c) begin
            dout_nxt_c = din_pw_c;
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Access_Grant <= 1'b0;
            Locked       <= 1'b0;
            Deny         <= 1'b0;
            wren         <= 1'b0;
            Address      <= '0;
            Data_Out     <= '0;
        end else begin
            Access_Grant <= (state_nxt == GRANT);
            Locked       <= (state_nxt == LOCKOUT);
            Deny         <= (state_nxt == DENY);
            wren         <= (state_nxt == WRITE);
            Address      <= addr_nxt_c;
            Data_Out     <= dout_nxt_c;
        end
    end

    // Entered password, user ID, fetched password and read-latency counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pw_reg  <= '0;
            user_id <= '0;
            mem_reg <= '0;
            lat_cnt <= '0;
        end else begin
            if (take_entry_c) begin
                pw_reg  <= din_pw_c;
                user_id <= User_Sel;
                lat_cnt <= LAT_W'(MEM_LAT - 1);
            end else if (take_change_c) begin
                pw_reg  <= din_pw_c;
            end else if ((state == FETCH) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (capture_c) begin
                mem_reg <= Memory_Data_In;
            end
        end
    end

    // Per-user fail counter bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_USERS; i++) begin
                fail_cnt[i] <= '0;
            end
        end else if (fail_clr_c) begin
            fail_cnt[user_id] <= '0;
        end else if (fail_bump_c) begin
            fail_cnt[user_id] <= fail_inc_c;
        end
    end

endmodule

// File: tb/tb_multi_user_access_ctrl.sv
// Self-checking bench for multi_user_access_ctrl: directed scenarios followed
// by random entries, all checked against a per-user password/fail-count model.
module tb_multi_user_access_ctrl;

    localparam int PW_W     = 16;
    localparam int USER_W   = 2;
    localparam int ADDR_W   = 8;
    localparam int BASE     = 254;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_CYC = 20;
    localparam int GNT_CYC  = 12;
    localparam int NU       = 4;
    localparam logic [15:0] INIT_PW [NU] = '{16'hA5C3, 16'h0F0F, 16'h1476, 16'h7E21};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    // Instance with single-cycle memory latency
    logic [PW_W:0]     din;
    logic              load;
    logic [USER_W-1:0] sel;
    logic [PW_W-1:0]   mdin;
    logic              grant, wren, locked, deny;
    logic [ADDR_W-1:0] addr;
    logic [PW_W-1:0]   dout;

    // Instance with three-cycle memory latency
    logic [PW_W:0]     din3;
    logic              load3;
    logic [USER_W-1:0] sel3;
    logic [PW_W-1:0]   mdin3;
    logic              grant3, wren3, locked3, deny3;
    logic [ADDR_W-1:0] addr3;
    logic [PW_W-1:0]   dout3;

    multi_user_access_ctrl #(
        .PW_W(PW_W), .USER_W(USER_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MEM_LAT(1),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCK_CYC), .GRANT_CYC(GNT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .Data_In(din), .Data_In_Load(load), .User_Sel(sel),
        .Memory_Data_In(mdin), .Access_Grant(grant), .Address(addr), .wren(wren),
        .Data_Out(dout), .Locked(locked), .Deny(deny)
    );

    multi_user_access_ctrl #(
        .PW_W(PW_W), .USER_W(USER_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MEM_LAT(3),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCK_CYC), .GRANT_CYC(GNT_CYC)
    ) dut3 (
        .clk(clk), .rst(rst), .Data_In(din3), .Data_In_Load(load3), .User_Sel(sel3),
        .Memory_Data_In(mdin3), .Access_Grant(grant3), .Address(addr3), .wren(wren3),
        .Data_Out(dout3), .Locked(locked3), .Deny(deny3)
    );

    // Password memories: combinational read for latency 1, two address stages for latency 3
    logic [PW_W-1:0]   mem  [256];
    logic [PW_W-1:0]   mem3 [256];
    logic [ADDR_W-1:0] a3_q1, a3_q2;
    assign mdin  = mem[addr];
    assign mdin3 = mem3[a3_q2];

    always @(posedge clk) begin
        a3_q1 <= addr3;
        a3_q2 <= a3_q1;
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= '0;
                mem3[i] <= '0;
            end
            for (int u = 0; u < NU; u++) begin
                mem[8'(BASE + u)]  <= INIT_PW[u];
                mem3[8'(BASE + u)] <= INIT_PW[u];
            end
        end else begin
            if (wren)  mem[addr]   <= dout;
            if (wren3) mem3[addr3] <= dout3;
        end
    end

    // Reference model: stored password and consecutive-failure count per user
    logic [15:0] model_pw   [NU];
    int          model_fail [NU];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] uaddr(input int u);
        return ADDR_W'(BASE + u);
    endfunction

    // One password entry; follows it through grant, deny and any lockout
    task automatic entry(input int u, input logic [15:0] pw, input bit poke_fetch,
                         input bit poke_lock, output bit match);
        bit lock_exp;
        match = (pw == model_pw[u]);
        din  = {1'b0, pw};
        sel  = USER_W'(u);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("fetch_addr", 32'(addr), 32'(uaddr(u)));
        check("fetch_grant", 32'(grant), 32'(0));
        if (poke_fetch) begin
            din  = {1'b0, model_pw[(u + 1) % NU]};
            sel  = USER_W'((u + 1) % NU);
            load = 1'b1;
        end
        tick();
        load = 1'b0;
        check("compare_addr", 32'(addr), 32'(0));
        check("compare_deny", 32'(deny), 32'(0));
        tick();
        check("result_grant", 32'(grant), 32'(match));
        check("result_deny", 32'(deny), 32'(!match));
        check("result_addr", 32'(addr), 32'(0));
        if (match) begin
            model_fail[u] = 0;
        end else begin
            model_fail[u] = (model_fail[u] < MAX_FAIL) ? model_fail[u] + 1 : MAX_FAIL;
            lock_exp = (model_fail[u] == MAX_FAIL);
            tick();
            check("deny_width", 32'(deny), 32'(0));
            check("lock_start", 32'(locked), 32'(lock_exp));
            if (lock_exp) begin
                if (poke_lock) begin
                    din  = {1'b0, model_pw[0]};
                    sel  = '0;
                    load = 1'b1;
                end
                for (int c = 1; c < LOCK_CYC; c++) begin
                    tick();
                    load = 1'b0;
                    check("lock_hold", 32'(locked), 32'(1));
                    check("lock_addr", 32'(addr), 32'(0));
                end
                tick();
                check("lock_end", 32'(locked), 32'(0));
                check("lock_end_addr", 32'(addr), 32'(0));
                model_fail[u] = 0;
            end
        end
    endtask

    task automatic grant_logout();
        din  = {1'b0, 16'h0000};
        load = 1'b1;
        tick();
        load = 1'b0;
        check("logout_grant", 32'(grant), 32'(0));
        check("logout_wren", 32'(wren), 32'(0));
        check("logout_addr", 32'(addr), 32'(0));
    endtask

    task automatic grant_change(input int u, input logic [15:0] npw, input int wait_cyc);
        for (int c = 0; c < wait_cyc; c++) begin
            tick();
            check("grant_hold", 32'(grant), 32'(1));
        end
        din  = {1'b1, npw};
        load = 1'b1;
        tick();
        load = 1'b0;
        check("write_wren", 32'(wren), 32'(1));
        check("write_addr", 32'(addr), 32'(uaddr(u)));
        check("write_data", 32'(dout), 32'(npw));
        check("write_grant", 32'(grant), 32'(0));
        model_pw[u] = npw;
        tick();
        check("post_write_wren", 32'(wren), 32'(0));
        check("post_write_addr", 32'(addr), 32'(0));
        check("post_write_data", 32'(dout), 32'(0));
    endtask

    task automatic grant_timeout();
        for (int c = 1; c < GNT_CYC; c++) begin
            tick();
            check("grant_hold", 32'(grant), 32'(1));
        end
        tick();
        check("grant_timeout", 32'(grant), 32'(0));
    endtask

    // Bound on total run time
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit m;
        int u;
        logic [15:0] pw;

        din = '0; load = 1'b0; sel = '0;
        din3 = '0; load3 = 1'b0; sel3 = '0;
        for (int i = 0; i < NU; i++) begin
            model_pw[i]   = INIT_PW[i];
            model_fail[i] = 0;
        end

        // Reset state
        tick();
        tick();
        mem_init = 1'b0;
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_addr", 32'(addr), 32'(0));
        check("rst_wren", 32'(wren), 32'(0));
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_locked", 32'(locked), 32'(0));
        check("rst_deny", 32'(deny), 32'(0));
        rst = 1'b1;
        tick();

        // Three-cycle memory latency: grant after E0+4
        din3  = {1'b0, INIT_PW[1]};
        sel3  = 2'd1;
        load3 = 1'b1;
        tick();
        load3 = 1'b0;
        check("lat3_addr", 32'(addr3), 32'(uaddr(1)));
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("lat3_wait_grant", 32'(grant3), 32'(0));
            check("lat3_addr_hold", 32'(addr3), (k < 3) ? 32'(uaddr(1)) : 32'(0));
        end
        tick();
        check("lat3_grant", 32'(grant3), 32'(1));
        check("lat3_deny", 32'(deny3), 32'(0));
        check("lat3_locked", 32'(locked3), 32'(0));

        // Correct entry for user 2 with a dropped load during FETCH, then change password
        entry(2, 16'h1476, 1'b1, 1'b0, m);
        check("user2_granted", 32'(m), 32'(1));
        grant_change(2, 16'h4789, 0);
        entry(2, 16'h4789, 1'b0, 1'b0, m);
        grant_timeout();

        // Three failures for user 1 lock everyone out; a load during lockout is dropped
        entry(1, 16'h0000, 1'b0, 1'b0, m);
        entry(1, 16'h0000, 1'b0, 1'b0, m);
        entry(1, 16'h0000, 1'b0, 1'b1, m);

        // Per-user isolation: user 0 success does not clear user 1's count
        entry(1, 16'h0000, 1'b0, 1'b0, m);
        entry(1, 16'h0000, 1'b0, 1'b0, m);
        entry(0, model_pw[0], 1'b0, 1'b0, m);
        grant_logout();
        entry(1, 16'h0000, 1'b0, 1'b0, m);

        // Load on the grant-expiry cycle wins over the timeout
        entry(3, model_pw[3], 1'b0, 1'b0, m);
        grant_change(3, 16'h3333, GNT_CYC - 1);

        // Reset during WRITE: outputs clear at once, nothing written, counters cleared
        entry(3, model_pw[3] ^ 16'h0001, 1'b0, 1'b0, m);
        entry(3, model_pw[3] ^ 16'h0001, 1'b0, 1'b0, m);
        entry(2, model_pw[2], 1'b0, 1'b0, m);
        din  = {1'b1, 16'hBEEF};
        load = 1'b1;
        tick();
        load = 1'b0;
        check("rw_wren_before", 32'(wren), 32'(1));
        #2;
        rst = 1'b0;
        #1;
        check("rw_wren", 32'(wren), 32'(0));
        check("rw_addr", 32'(addr), 32'(0));
        check("rw_dout", 32'(dout), 32'(0));
        check("rw_grant", 32'(grant), 32'(0));
        tick();
        rst = 1'b1;
        for (int i = 0; i < NU; i++) model_fail[i] = 0;
        entry(3, model_pw[3] ^ 16'h0001, 1'b0, 1'b0, m);
        entry(2, model_pw[2], 1'b0, 1'b0, m);
        check("rw_old_pw_kept", 32'(m), 32'(1));
        grant_logout();

        // Random entries, outcomes and grant endings
        for (int it = 0; it < 40; it++) begin
            u  = int'($urandom_range(NU - 1));
            pw = ($urandom_range(1) == 1) ? model_pw[u] : 16'($urandom);
            entry(u, pw, 1'b0, 1'b0, m);
            if (m) begin
                case ($urandom_range(2))
                    0:       grant_logout();
                    1:       grant_change(u, 16'($urandom), int'($urandom_range(GNT_CYC - 1)));
                    default: grant_timeout();
                endcase
            end
        end

        check("final_wren", 32'(wren), 32'(0));
        check("final_locked", 32'(locked), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_user_access_ctrl.md
# multi_user_access_ctrl

Parametrised, multi-user access controller and next generation of the single-user password FSM. It fetches a selected user's stored password from external synchronous memory and compares it with the entered value. It keeps a separate saturating fail counter per user, enforces a timed global lockout after repeated failures, and lets a granted user write a new password back to memory. It sits between the keypad/data-entry front end and the password memory.

## Interface
Parameters:
- PW_W, 16: password width.
- USER_W, 2: user-select width; 2**USER_W users.
- ADDR_W, 16: memory address width.
- BASE_ADDR, 0: address of user 0's password; user n is at BASE_ADDR+n.
- MEM_LAT, 1: memory read latency in cycles, ≥1.
- MAX_FAIL, 3: consecutive failures that trigger lockout, ≥1.
- LOCKOUT_CYC, 1000: lockout duration in cycles.
- GRANT_CYC, 500: grant timeout in cycles.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- Data_In, in, PW_W+1: MSB is the change flag; [PW_W-1:0] is the password value.
- Data_In_Load, in, 1: one-cycle strobe qualifying Data_In and User_Sel.
- User_Sel, in, USER_W: user ID, sampled with Data_In_Load.
- Memory_Data_In, in, PW_W: memory read data.
- Access_Grant, out, 1: high while in GRANT.
- Address, out, ADDR_W: memory address.
- wren, out, 1: memory write enable.
- Data_Out, out, PW_W: memory write data.
- Locked, out, 1: high during lockout.
- Deny, out, 1: one-cycle pulse on a failed compare.

## Operation
- States: IDLE, FETCH, COMPARE, GRANT, WRITE, DENY, LOCKOUT.
- IDLE:
  - Load with MSB=0: latch the password into the user register and User_Sel into the user-ID register, drive Address=BASE_ADDR+User_Sel, go to FETCH.
  - Load with MSB=1: ignore.
- FETCH: hold Address. After MEM_LAT edges, capture Memory_Data_In into the memory register and go to COMPARE.
- COMPARE: full PW_W-bit equality check.
  - Match: clear that user's fail counter, go to GRANT.
  - Mismatch: go to DENY.
- DENY: pulse Deny for one cycle and increment the user's fail counter.
  - Counter reaches MAX_FAIL: go to LOCKOUT.
  - Otherwise: go to IDLE.
- LOCKOUT: Locked=1, down-counter loaded with LOCKOUT_CYC-1. At zero, clear the offending user's counter and go to IDLE.
- GRANT: Access_Grant=1, timeout counter runs.
  - Load with MSB=1: latch the new password and go to WRITE.
  - Load with MSB=0: logout, go to IDLE.
  - Timeout expiry: go to IDLE.
- WRITE: one cycle with wren=1, Address=BASE_ADDR+latched user ID, Data_Out=new password, then go to IDLE. Grant drops on entry to WRITE.
- Loads arriving in FETCH, COMPARE, DENY, WRITE or LOCKOUT are dropped, not queued.
- Fail counters are $clog2(MAX_FAIL+1) bits and saturate at MAX_FAIL. Address arithmetic is modulo 2**ADDR_W.

## Timing
- Reset values: state IDLE; all fail counters 0; all outputs 0. Address and Data_Out are 0 outside FETCH and WRITE.
- Latency: a load sampled at edge E0 gives Access_Grant high (or the Deny pulse) after edge E0+MEM_LAT+1.
- Deny is high exactly one cycle. Lockout then starts after the following edge, and Locked stays high for exactly LOCKOUT_CYC cycles.
- Grant lasts at most GRANT_CYC cycles. If a load arrives on the same edge the timeout expires, the load wins.
- wren is a single-cycle pulse and never asserts outside WRITE.
- Reset asserted mid-operation (including WRITE): all outputs clear immediately, with no partial write beyond the current cycle.
- Failures are tracked per user. A success for user A does not clear user B's counter, and lockout blocks all users.

## Structure
- Package access_ctrl_pkg holds:
  - the state enum;
  - the change-flag bit index;
  - a function returning the fail-counter width.
- Sub-module access_lockout_timer: a parametrised loadable down-counter with a done flag. Instantiate it twice, once for lockout and once for grant timeout.
- The fail-counter bank is an in-module register array indexed by user ID.

## Test plan
- Correct entry: MEM_LAT=1, user 2 stores 16'h1476, load {0,16'h1476} with User_Sel=2.
  - Address=BASE+2 after E0.
  - Access_Grant high after E0+2.
  - Deny never asserts.
- Change password: while granted, load {1,16'h4789}.
  - One cycle with wren=1, Address=BASE+2, Data_Out=16'h4789.
  - Access_Grant low.
  - Next entry of 16'h4789 is granted.
- Lockout, MAX_FAIL=3: three wrong entries of 16'h0000 for user 1.
  - Three Deny pulses.
  - Locked high for exactly LOCKOUT_CYC cycles.
  - A load during lockout (user 0, correct password) causes no Address change.
- Per-user isolation: two failures for user 1, a success for user 0, one failure for user 1.
  - Lockout asserts, because user 1's counter was not cleared.
- Timeouts and drops:
  - Grant with no further input drops after GRANT_CYC cycles.
  - A load in FETCH is ignored.
  - MEM_LAT=3 gives grant after E0+4.
- Reset during WRITE: assert rst while wren=1.
  - wren, Address and Data_Out go to 0 asynchronously.
  - State returns to IDLE and fail counters to 0.
